// File: rtl/ym3438_mix_pkg.sv
// rtl/ym3438_mix_pkg.sv - shared constants and helpers for the stereo frame mixer
package ym3438_mix_pkg;

    localparam int PAN_L = 1;
    localparam int PAN_R = 0;

    // Headroom for CH_COUNT worst-case terms (ladder adds one LSB) plus sign.
    function automatic int acc_w(input int in_w, input int ch_count);
        return in_w + $clog2(ch_count) + 1;
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] acc,
                                                 input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (out_w >= 64) begin
            return acc;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/ym3438_mix_slot_term.sv
// rtl/ym3438_mix_slot_term.sv - per-side slot contribution, clean or ladder-offset
module ym3438_mix_slot_term #(
    parameter int IN_W   = 9,
    parameter int LADDER = 0
) (
    input  logic signed [IN_W-1:0] ch_val_i,
    input  logic                   act_i,
    output logic signed [IN_W:0]   term_o
);

    logic signed [IN_W:0] ext;

    assign ext = {ch_val_i[IN_W-1], ch_val_i};

    // Ladder mode: silent channels still leak +1/-1 depending on the value sign.
    always_comb begin
        term_o = '0;
        if (LADDER != 0) begin
            if (!ch_val_i[IN_W-1]) begin
                term_o = act_i ? ext + (IN_W+1)'(1) : (IN_W+1)'(1);
            end else begin
                term_o = act_i ? ext : '1;
            end
        end else begin
            term_o = act_i ? ext : '0;
        end
    end

endmodule

// File: rtl/ym3438_mix_acc.sv
// rtl/ym3438_mix_acc.sv - frame accumulator producing a saturated stereo sample pair
module ym3438_mix_acc
    import ym3438_mix_pkg::*;
#(
    parameter int CH_COUNT = 6,
    parameter int IN_W     = 9,
    parameter int OUT_W    = 16,
    parameter int LADDER   = 0
) (
    input  logic                    MCLK,
    input  logic                    IC,
    input  logic                    slot_en,
    input  logic                    frame_sync,
    input  logic signed [IN_W-1:0]  ch_val,
    input  logic [1:0]              ch_pan,
    input  logic                    ch_en,
    output logic signed [OUT_W-1:0] out_l,
    output logic signed [OUT_W-1:0] out_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    sync_err,
    input  logic                    flag_clr
);

    localparam int ACC_W = acc_w(IN_W, CH_COUNT);
    localparam int CNT_W = $clog2(CH_COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CH_COUNT - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [OUT_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    sync_err_q, sync_err_d;

    logic signed [IN_W:0]    term_l, term_r;
    logic signed [ACC_W-1:0] sum_l, sum_r;
    logic signed [OUT_W-1:0] smp_l, smp_r;
    logic                    first_slot, last_slot, complete, mid_sync;

    ym3438_mix_slot_term #(.IN_W(IN_W), .LADDER(LADDER)) u_term_l (
        .ch_val_i (ch_val),
        .act_i    (ch_en & ch_pan[PAN_L]),
        .term_o   (term_l)
    );

    ym3438_mix_slot_term #(.IN_W(IN_W), .LADDER(LADDER)) u_term_r (
        .ch_val_i (ch_val),
        .act_i    (ch_en & ch_pan[PAN_R]),
        .term_o   (term_r)
    );

    always_comb begin
        // frame_sync re-aligns: the current slot becomes slot 0 regardless of the count.
        first_slot = frame_sync | (cnt_q == '0);
        last_slot  = !frame_sync && (cnt_q == LAST);
        mid_sync   = slot_en & frame_sync & (cnt_q != '0);
        complete   = slot_en & last_slot;

        sum_l = (first_slot ? '0 : acc_l_q) + ACC_W'(term_l);
        sum_r = (first_slot ? '0 : acc_r_q) + ACC_W'(term_r);
        smp_l = OUT_W'(sat_s(64'(sum_l), OUT_W));
        smp_r = OUT_W'(sat_s(64'(sum_r), OUT_W));

        cnt_d   = cnt_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        out_l_d = out_l_q;
        out_r_d = out_r_q;
        valid_d = valid_q;

        if (slot_en) begin
            if (frame_sync) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            acc_l_d = sum_l;
            acc_r_d = sum_r;
        end

        if (complete) begin
            out_l_d = smp_l;
            out_r_d = smp_r;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        overrun_d  = flag_clr ? 1'b0 : (overrun_q | (complete & valid_q & ~out_ready));
        sync_err_d = flag_clr ? 1'b0 : (sync_err_q | mid_sync);
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            cnt_q      <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            out_l_q    <= '0;
            out_r_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            out_l_q    <= out_l_d;
            out_r_q    <= out_r_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ym3438_mix_acc.sv
// tb/tb_ym3438_mix_acc.sv - self-checking bench for ym3438_mix_acc
module tb_ym3438_mix_acc;

    localparam int CH = 6;

    logic MCLK = 1'b0;
    logic IC   = 1'b0;
    logic slot_en = 1'b0, frame_sync = 1'b0, ch_en = 1'b0, out_ready = 1'b0, flag_clr = 1'b0;
    logic [1:0] ch_pan = 2'b00;
    logic signed [8:0] ch_val = '0;

    logic signed [15:0] l0, r0, l1, r1;
    logic signed [9:0]  l2, r2;
    logic v0, v1, v2, ov0, ov1, ov2, se0, se1, se2;

    always #5 MCLK = ~MCLK;

    ym3438_mix_acc #(.CH_COUNT(CH), .IN_W(9), .OUT_W(16), .LADDER(0)) dut0 (
        .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .frame_sync(frame_sync), .ch_val(ch_val),
        .ch_pan(ch_pan), .ch_en(ch_en), .out_l(l0), .out_r(r0), .out_valid(v0),
        .out_ready(out_ready), .overrun(ov0), .sync_err(se0), .flag_clr(flag_clr));

    ym3438_mix_acc #(.CH_COUNT(CH), .IN_W(9), .OUT_W(16), .LADDER(1)) dut1 (
        .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .frame_sync(frame_sync), .ch_val(ch_val),
        .ch_pan(ch_pan), .ch_en(ch_en), .out_l(l1), .out_r(r1), .out_valid(v1),
        .out_ready(out_ready), .overrun(ov1), .sync_err(se1), .flag_clr(flag_clr));

    ym3438_mix_acc #(.CH_COUNT(CH), .IN_W(9), .OUT_W(10), .LADDER(0)) dut2 (
        .MCLK(MCLK), .IC(IC), .slot_en(slot_en), .frame_sync(frame_sync), .ch_val(ch_val),
        .ch_pan(ch_pan), .ch_en(ch_en), .out_l(l2), .out_r(r2), .out_valid(v2),
        .out_ready(out_ready), .overrun(ov2), .sync_err(se2), .flag_clr(flag_clr));

    int total = 0;
    int bad   = 0;

    // Reference model state: slot position, per-frame running sums, expected outputs.
    int m_idx;
    int sc_l, sc_r, sd_l, sd_r;
    int e_l0, e_r0, e_l1, e_r1, e_l2, e_r2;
    bit m_v, m_ov, m_se;

    typedef struct {
        bit fs; bit se; int val; bit [1:0] pan; bit en; bit rdy; bit clr;
        bit hard; int el; int er; bit ev;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int term_of(input int val, input bit act, input bit ladder);
        if (!ladder) return act ? val : 0;
        if (val >= 0) return act ? val + 1 : 1;
        return act ? val : -1;
    endfunction

    function automatic int clamp(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        m_idx = 0; sc_l = 0; sc_r = 0; sd_l = 0; sd_r = 0;
        e_l0 = 0; e_r0 = 0; e_l1 = 0; e_r1 = 0; e_l2 = 0; e_r2 = 0;
        m_v = 0; m_ov = 0; m_se = 0;
    endtask

    task automatic model_edge(input bit fs, input bit se, input int val, input bit [1:0] pan,
                              input bit en, input bit rdy, input bit clr);
        bit comp = 0, setov = 0, setse = 0;
        if (se) begin
            if (fs) begin
                if (m_idx != 0) setse = 1;
                m_idx = 0;
            end
            if (m_idx == 0) begin
                sc_l = 0; sc_r = 0; sd_l = 0; sd_r = 0;
            end
            sc_l += term_of(val, en & pan[1], 0);
            sc_r += term_of(val, en & pan[0], 0);
            sd_l += term_of(val, en & pan[1], 1);
            sd_r += term_of(val, en & pan[0], 1);
            if (m_idx == CH - 1) comp = 1;
            m_idx = (m_idx + 1) % CH;
        end
        if (comp) begin
            if (m_v && !rdy) setov = 1;
            e_l0 = clamp(sc_l, 16); e_r0 = clamp(sc_r, 16);
            e_l1 = clamp(sd_l, 16); e_r1 = clamp(sd_r, 16);
            e_l2 = clamp(sc_l, 10); e_r2 = clamp(sc_r, 10);
            m_v = 1;
        end else if (m_v && rdy) begin
            m_v = 0;
        end
        m_ov = clr ? 0 : (m_ov | setov);
        m_se = clr ? 0 : (m_se | setse);
    endtask

    task automatic check_all();
        chk("l0", l0, e_l0); chk("r0", r0, e_r0);
        chk("l1", l1, e_l1); chk("r1", r1, e_r1);
        chk("l2", l2, e_l2); chk("r2", r2, e_r2);
        chk("valid0", v0, m_v); chk("valid1", v1, m_v); chk("valid2", v2, m_v);
        chk("overrun", ov0, m_ov); chk("sync_err", se0, m_se);
    endtask

    task automatic step(input bit fs, input bit se, input int val, input bit [1:0] pan,
                        input bit en, input bit rdy, input bit clr);
        frame_sync = fs; slot_en = se; ch_val = val[8:0]; ch_pan = pan;
        ch_en = en; out_ready = rdy; flag_clr = clr;
        @(posedge MCLK);
        model_edge(fs, se, val, pan, en, rdy, clr);
        @(negedge MCLK);
        check_all();
    endtask

    task automatic frame(input int val, input bit [1:0] pan, input bit en, input bit rdy);
        for (int i = 0; i < CH; i++) step(i == 0, 1, val, pan, en, rdy, 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_l0", l0, 0); chk("rst_r0", r0, 0); chk("rst_valid", v0, 0);
        chk("rst_overrun", ov0, 0); chk("rst_sync_err", se0, 0);
        @(negedge MCLK);
        IC = 1'b1;
        @(negedge MCLK);

        for (int i = 0; i < CH; i++)
            tbl.push_back('{i == 0, 1, 10, 2'b11, 1, 0, 0, i == CH - 1, 60, 60, 1});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 1, 0, 1, 60, 60, 0});
        tbl.push_back('{1, 1, 100, 2'b10, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, -40, 2'b01, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 77, 2'b11, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 77, 2'b11, 1, 0, 0, 0, 0, 0, 0});
        for (int i = 2; i < CH; i++)
            tbl.push_back('{0, 1, 7, 2'b11, 0, 0, 0, i == CH - 1, 100, -40, 1});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 1, 0, 1, 100, -40, 0});

        foreach (tbl[i]) begin
            step(tbl[i].fs, tbl[i].se, tbl[i].val, tbl[i].pan, tbl[i].en, tbl[i].rdy, tbl[i].clr);
            if (tbl[i].hard) begin
                chk("tbl_out_l", l0, tbl[i].el);
                chk("tbl_out_r", r0, tbl[i].er);
                chk("tbl_valid", v0, tbl[i].ev);
            end
        end

        // Ladder offsets
        for (int i = 0; i < CH; i++) step(i == 0, 1, (i % 2) ? -5 : 5, 2'b11, 0, 1, 0);
        chk("ladder_idle_l", l1, 0); chk("ladder_idle_r", r1, 0);
        frame(5, 2'b10, 1, 1);
        chk("ladder_l", l1, 36); chk("ladder_r", r1, 6);

        // Saturation on the narrow instance
        frame(255, 2'b11, 1, 1);
        chk("sat_pos_l", l2, 511); chk("sat_pos_r", r2, 511); chk("wide_pos", l0, 1530);
        frame(-256, 2'b11, 1, 1);
        chk("sat_neg_l", l2, -512); chk("sat_neg_r", r2, -512); chk("wide_neg", l0, -1536);

        // Overrun, flag clear, handshake on completion edge, clear-beats-set
        step(0, 0, 0, 2'b00, 0, 1, 0);
        frame(1, 2'b11, 1, 0);
        frame(2, 2'b11, 1, 0);
        chk("ovr_set", ov0, 1); chk("ovr_second_l", l0, 12); chk("ovr_valid", v0, 1);
        step(0, 0, 0, 2'b00, 0, 0, 1);
        chk("ovr_clr", ov0, 0);
        for (int i = 0; i < CH; i++) step(i == 0, 1, 3, 2'b11, 1, i == CH - 1, 0);
        chk("hs_no_ovr", ov0, 0); chk("hs_valid", v0, 1); chk("hs_l", l0, 18);
        for (int i = 0; i < CH; i++) step(i == 0, 1, 4, 2'b11, 1, 0, i == CH - 1);
        chk("clr_priority", ov0, 0); chk("clr_pri_l", l0, 24);

        // Mid-frame frame_sync
        step(0, 0, 0, 2'b00, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(i == 0, 1, 50, 2'b11, 1, 0, 0);
        step(1, 1, 1, 2'b11, 1, 0, 0);
        chk("sync_err_set", se0, 1); chk("sync_no_valid", v0, 0);
        for (int i = 1; i < CH; i++) step(0, 1, 1, 2'b11, 1, 0, 0);
        chk("sync_sum", l0, 6); chk("sync_valid", v0, 1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) step(0, 1, 9, 2'b11, 1, 0, 0);
        #2 IC = 1'b0;
        #1;
        chk("arst_l0", l0, 0); chk("arst_r0", r0, 0); chk("arst_l1", l1, 0);
        chk("arst_valid", v0, 0); chk("arst_sync_err", se0, 0); chk("arst_overrun", ov0, 0);
        model_reset();
        @(negedge MCLK);
        IC = 1'b1;
        for (int i = 0; i < CH; i++) step(0, 1, 2, 2'b11, 1, 1, 0);
        chk("post_rst_l", l0, 12);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int v;
            v = int'($urandom_range(0, 511)) - 256;
            step($urandom % 8 == 0, $urandom % 4 != 0, v, 2'($urandom), $urandom % 4 != 0,
                 $urandom % 2 == 0, $urandom % 16 == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
